// File: rtl/acq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acq_pkg
// Description : Shared state encoding and default sizing for the acquisition
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package acq_pkg;

    localparam int c_CNT_W_DEF       = 16;
    localparam int c_HOLDOFF_CYC_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLDOFF = 3'd4
    } acq_state_t;

endpackage
`default_nettype wire

// File: rtl/acq_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : acq_edge_det
// Description : Rising-edge detector; the previous level is registered and
//               the edge is flagged in the same cycle the input goes high.
// Revision    : 1.0 - initial release
// ============================================================================
module acq_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/acq_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : acq_seq_ctrl
// Description : Arm / trigger / post-trigger delay / N-sample capture
//               sequencer for one acquisition channel.
//               Optional macro ACQ_AUTO_REARM_EN: HOLDOFF re-arms instead of
//               returning to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module acq_seq_ctrl
    import acq_pkg::*;
#(
    parameter int CNT_W       = c_CNT_W_DEF,
    parameter int HOLDOFF_CYC = c_HOLDOFF_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] n_samples_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic             sample_valid_i,
    output logic             adc_en_o,
    output logic             capture_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o,
    output logic [2:0]       state_o
);

    localparam int c_HOLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

    acq_state_t          r_state,  w_state_nxt;
    logic [CNT_W-1:0]    r_n_lat,  w_n_lat_nxt;
    logic [CNT_W-1:0]    r_d_lat,  w_d_lat_nxt;
    logic [CNT_W-1:0]    r_dcnt,   w_dcnt_nxt;
    logic [CNT_W-1:0]    r_scnt,   w_scnt_nxt;
    logic [c_HOLD_W-1:0] r_hcnt,   w_hcnt_nxt;
    logic                r_done,   w_done_nxt;
    logic                r_overrun, w_overrun_nxt;
    logic                w_trig_edge;

    acq_edge_det u_trig_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (trig_i),
        .o_rise (w_trig_edge)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_n_lat   <= '0;
            r_d_lat   <= '0;
            r_dcnt    <= '0;
            r_scnt    <= '0;
            r_hcnt    <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_n_lat   <= w_n_lat_nxt;
            r_d_lat   <= w_d_lat_nxt;
            r_dcnt    <= w_dcnt_nxt;
            r_scnt    <= w_scnt_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_n_lat_nxt   = r_n_lat;
        w_d_lat_nxt   = r_d_lat;
        w_dcnt_nxt    = r_dcnt;
        w_scnt_nxt    = r_scnt;
        w_hcnt_nxt    = r_hcnt;
        w_done_nxt    = 1'b0;
        w_overrun_nxt = r_overrun;

        if (abort_i) begin
            w_state_nxt = ST_IDLE;
            w_dcnt_nxt  = '0;
            w_scnt_nxt  = '0;
            w_hcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm_i) begin
                        w_n_lat_nxt   = n_samples_i;
                        w_d_lat_nxt   = delay_i;
                        w_overrun_nxt = 1'b0;
                        // A zero-length request completes without arming.
                        if (n_samples_i == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (w_trig_edge) begin
                        w_dcnt_nxt  = r_d_lat;
                        w_scnt_nxt  = r_n_lat;
                        w_state_nxt = (r_d_lat != '0) ? ST_DELAY : ST_CAPTURE;
                    end
                end
                ST_DELAY: begin
                    if (sample_valid_i && (r_dcnt != '0)) begin
                        w_dcnt_nxt = r_dcnt - CNT_W'(1);
                        if (r_dcnt == CNT_W'(1)) begin
                            w_state_nxt = ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid_i && (r_scnt != '0)) begin
                        w_scnt_nxt = r_scnt - CNT_W'(1);
                        if (r_scnt == CNT_W'(1)) begin
                            w_done_nxt  = 1'b1;
                            w_hcnt_nxt  = c_HOLD_W'(HOLDOFF_CYC - 1);
                            w_state_nxt = ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (r_hcnt == '0) begin
`ifdef ACQ_AUTO_REARM_EN
                        w_state_nxt   = ST_ARMED;
                        w_overrun_nxt = 1'b0;
`else
                        w_state_nxt   = ST_IDLE;
`endif
                    end else begin
                        w_hcnt_nxt = r_hcnt - c_HOLD_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // A late trigger is flagged even if the same cycle aborts.
        if (w_trig_edge && ((r_state == ST_DELAY) || (r_state == ST_CAPTURE))) begin
            w_overrun_nxt = 1'b1;
        end
    end

    assign adc_en_o  = (r_state == ST_ARMED) || (r_state == ST_DELAY) ||
                       (r_state == ST_CAPTURE);
    assign capture_o = (r_state == ST_CAPTURE) && sample_valid_i;
    assign busy_o    = (r_state != ST_IDLE);
    assign done_o    = r_done;
    assign overrun_o = r_overrun;
    assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_acq_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_acq_seq_ctrl
// Description : Self-checking bench for acq_seq_ctrl with a sample-count
//               based reference model and directed plus random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_seq_ctrl;

    localparam int CNT_W   = 16;
    localparam int HOLDOFF = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             arm_i = 1'b0;
    logic             abort_i = 1'b0;
    logic             trig_i = 1'b0;
    logic [CNT_W-1:0] n_samples_i = '0;
    logic [CNT_W-1:0] delay_i = '0;
    logic             sample_valid_i = 1'b0;
    logic             adc_en_o;
    logic             capture_o;
    logic             busy_o;
    logic             done_o;
    logic             overrun_o;
    logic [2:0]       state_o;

    acq_seq_ctrl #(.CNT_W(CNT_W), .HOLDOFF_CYC(HOLDOFF)) dut (
        .clk            (clk),
        .rst            (rst),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .trig_i         (trig_i),
        .n_samples_i    (n_samples_i),
        .delay_i        (delay_i),
        .sample_valid_i (sample_valid_i),
        .adc_en_o       (adc_en_o),
        .capture_o      (capture_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overrun_o      (overrun_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phases plus a count of valid samples seen since trigger.
    localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_HOLD = 3;
    int m_phase, m_seen, m_held, m_nlat, m_dlat;
    bit m_done, m_ovr, m_prev;

    function automatic int exp_state();
        case (m_phase)
            P_ARMED: return 1;
            P_RUN:   return (m_seen < m_dlat) ? 2 : 3;
            P_HOLD:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] model_vec();
        int  st;
        logic adc, cap, bsy;
        st  = exp_state();
        adc = (st >= 1) && (st <= 3);
        cap = (st == 3) && sample_valid_i;
        bsy = (st != 0);
        return {st[2:0], adc, cap, bsy, m_done, m_ovr};
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_phase = P_IDLE; m_seen = 0; m_held = 0; m_nlat = 0; m_dlat = 0;
                m_done = 0; m_ovr = 0; m_prev = 0;
            end else begin
                bit e;
                int st;
                e      = trig_i && !m_prev;
                m_prev = trig_i;
                st     = exp_state();
                m_done = 0;
                if (e && (st == 2 || st == 3)) m_ovr = 1;
                if (abort_i) begin
                    m_phase = P_IDLE;
                end else begin
                    case (m_phase)
                        P_IDLE: if (arm_i) begin
                            m_nlat = int'(n_samples_i);
                            m_dlat = int'(delay_i);
                            m_ovr  = 0;
                            if (m_nlat == 0) m_done = 1;
                            else m_phase = P_ARMED;
                        end
                        P_ARMED: if (e) begin
                            m_phase = P_RUN;
                            m_seen  = 0;
                        end
                        P_RUN: if (sample_valid_i) begin
                            m_seen++;
                            if (m_seen == m_dlat + m_nlat) begin
                                m_done  = 1;
                                m_phase = P_HOLD;
                                m_held  = 0;
                            end
                        end
                        default: begin
                            m_held++;
                            if (m_held == HOLDOFF) begin
`ifdef ACQ_AUTO_REARM_EN
                                m_phase = P_ARMED;
                                m_ovr   = 0;
`else
                                m_phase = P_IDLE;
`endif
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison and event counters for the directed scenarios.
    int cap_cnt, done_cnt, hold_cnt, skip_cnt, idle_cnt;
    logic [7:0] act_vec, exp_vec;

    initial begin
        forever begin
            @(negedge clk);
            act_vec = {state_o, adc_en_o, capture_o, busy_o, done_o, overrun_o};
            exp_vec = model_vec();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_errors++;
                $display("FAIL cycle_cmp {state,adc,cap,busy,done,ovr}: actual=%b expected=%b at t=%0t",
                         act_vec, exp_vec, $time);
            end
            cap_cnt  += int'(capture_o);
            done_cnt += int'(done_o);
            hold_cnt += int'(state_o == 3'd4);
            skip_cnt += int'((state_o == 3'd2) && sample_valid_i);
            idle_cnt += int'(!busy_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        cap_cnt = 0; done_cnt = 0; hold_cnt = 0; skip_cnt = 0; idle_cnt = 0;
    endtask

    task automatic arm_seq(input int n, input int d);
        n_samples_i = CNT_W'(n);
        delay_i     = CNT_W'(d);
        arm_i       = 1'b1;
        tick();
        arm_i       = 1'b0;
    endtask

    initial begin
        clr();
        repeat (3) tick();
        chk("reset_state", int'(state_o), 0);
        chk("reset_outs", int'({adc_en_o, capture_o, busy_o, done_o, overrun_o}), 0);
        rst = 1'b1;
        tick();

`ifndef ACQ_AUTO_REARM_EN
        // Basic capture
        arm_seq(4, 0);
        chk("armed_state", int'(state_o), 1);
        tick();
        trig_i = 1'b1; sample_valid_i = 1'b1; clr();
        tick();
        chk("trig_latency_state", int'(state_o), 3);
        trig_i = 1'b0;
        repeat (20) tick();
        chk("basic_captures", cap_cnt, 4);
        chk("basic_done", done_cnt, 1);
        chk("basic_holdoff", hold_cnt, HOLDOFF);
        chk("basic_final_state", int'(state_o), 0);

        // Post-trigger delay with sparse samples
        sample_valid_i = 1'b0;
        arm_seq(3, 5);
        tick();
        trig_i = 1'b1; clr();
        tick();
        trig_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sample_valid_i = (i % 2 == 0);
            tick();
        end
        sample_valid_i = 1'b0;
        chk("delay_skipped", skip_cnt, 5);
        chk("delay_captures", cap_cnt, 3);
        chk("delay_done", done_cnt, 1);

        // Overrun during capture
        arm_seq(8, 0);
        tick();
        trig_i = 1'b1; sample_valid_i = 1'b1; clr();
        tick();
        trig_i = 1'b0;
        tick(); tick();
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        repeat (20) tick();
        chk("overrun_set", int'(overrun_o), 1);
        chk("overrun_captures", cap_cnt, 8);
        chk("overrun_done", done_cnt, 1);
        arm_seq(8, 0);
        chk("overrun_cleared_by_arm", int'(overrun_o), 0);
        abort_i = 1'b1; tick(); abort_i = 1'b0; tick();

        // Abort during delay
        arm_seq(4, 10);
        tick();
        trig_i = 1'b1; clr();
        tick();
        trig_i = 1'b0;
        repeat (3) tick();
        chk("abort_pre_state", int'(state_o), 2);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_state", int'(state_o), 0);
        chk("abort_adc_en", int'(adc_en_o), 0);
        repeat (10) tick();
        chk("abort_no_done", done_cnt, 0);

        // Asynchronous reset mid-capture
        arm_seq(6, 0);
        tick();
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        tick(); tick();
        chk("rst_pre_state", int'(state_o), 3);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_outs",
            int'({state_o, adc_en_o, capture_o, busy_o, done_o, overrun_o}), 0);
        repeat (2) tick();
        rst = 1'b1;
        sample_valid_i = 1'b0;
        tick();
        arm_seq(2, 0);
        chk("rst_rearm_state", int'(state_o), 1);
        abort_i = 1'b1; tick(); abort_i = 1'b0; tick();
`else
        // Auto re-arm: two captures without returning to IDLE
        arm_seq(2, 0);
        tick();
        trig_i = 1'b1; sample_valid_i = 1'b1; clr();
        tick();
        trig_i = 1'b0;
        repeat (15) tick();
        chk("rearm_state", int'(state_o), 1);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        repeat (15) tick();
        chk("rearm_done_pulses", done_cnt, 2);
        chk("rearm_captures", cap_cnt, 4);
        chk("rearm_busy_gaps", idle_cnt, 0);
        abort_i = 1'b1; tick(); abort_i = 1'b0; sample_valid_i = 1'b0; tick();
        chk("rearm_abort_state", int'(state_o), 0);
`endif

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            arm_i          = ($urandom % 8) == 0;
            abort_i        = ($urandom % 64) == 0;
            sample_valid_i = ($urandom % 3) != 0;
            n_samples_i    = CNT_W'($urandom_range(0, 6));
            delay_i        = CNT_W'($urandom_range(0, 5));
            if (($urandom % 6) == 0) trig_i = ~trig_i;
            if (($urandom % 700) == 0) begin
                #2 rst = 1'b0;
                #1;
                chk("rnd_async_rst", int'({state_o, done_o, overrun_o}), 0);
                tick();
                rst = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
